// File: rtl/counter_pkg.sv
// counter_pkg: direction and boundary-mode encodings shared by the counter slice
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
endpackage

// File: rtl/count_prescaler.sv
// count_prescaler: emits one step per PRESCALE enabled cycles
// ports: clk, reset (async, active-high), en (advances phase), sync_clr (phase to 0), step (out)
module count_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic step
);
  generate
    if (PRESCALE == 1) begin : g_bypass
      assign step = en;
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] phase;
      assign step = en && phase == LAST;
      always_ff @(posedge clk or posedge reset)
        if (reset) phase <= '0;
        else if (sync_clr) phase <= '0;
        else if (en) phase <= step ? '0 : phase + 1'b1;
    end
  endgenerate
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with wrap/saturate, prescaler, tc, sticky ovf, compare
// ports: clk, reset (async, active-high), en, up_dn, sat_mode, clr, load, load_val, cmp_val
//        -> q (registered), tc (registered strobe), ovf (registered sticky), match (q == cmp_val)
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             match
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  logic step, up, sat, at_bound;
  logic [WIDTH-1:0] nxt, ld;
  count_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk(clk), .reset(reset), .en(en), .sync_clr(clr | load), .step(step)
  );
  assign up = up_dn == DIR_UP;
  assign sat = sat_mode == MODE_SAT;
  assign at_bound = up ? q == MAX : q == '0;
  // at the boundary, wrap jumps to the opposite end while saturate holds
  always_comb begin
    nxt = up ? (at_bound ? (sat ? MAX : '0) : q + 1'b1)
             : (at_bound ? (sat ? '0 : MAX) : q - 1'b1);
    ld = load_val > MAX ? MAX : load_val;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else if (clr) begin
      q <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      q <= ld;
      tc <= 1'b0;
    end else if (step) begin
      q <= nxt;
      tc <= at_bound;
      ovf <= ovf | at_bound;
    end else tc <= 1'b0;
  assign match = q == cmp_val;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed and random checks of two counter configurations against a spec-level model
module tb_updown_mod_counter;
  logic clk = 1'b0, reset = 1'b1;
  logic en = 1'b0, up_dn = 1'b1, sat_mode = 1'b0, clr = 1'b0, load = 1'b0;
  logic [2:0] load_val = '0, cmp_val = '0;
  logic [2:0] qa, qb;
  logic tca, ovfa, ma, tcb, ovfb, mb;
  int errors = 0, checks = 0;
  int mq[2], mtc[2], movf[2], mph[2];
  string tag = "reset";
  always #5 clk = ~clk;
  updown_mod_counter dut_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .clr(clr),
    .load(load), .load_val(load_val), .cmp_val(cmp_val), .q(qa), .tc(tca), .ovf(ovfa), .match(ma)
  );
  updown_mod_counter #(.WIDTH(3), .MAX_VAL(5), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .clr(clr),
    .load(load), .load_val(load_val), .cmp_val(cmp_val), .q(qb), .tc(tcb), .ovf(ovfb), .match(mb)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s got=%0d exp=%0d", tag, name, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mtc[i] = 0; movf[i] = 0; mph[i] = 0;
    end
  endtask
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int mx, ps;
      mx = (i == 0) ? 7 : 5;
      ps = (i == 0) ? 1 : 4;
      if (clr) begin
        mq[i] = 0; movf[i] = 0; mtc[i] = 0; mph[i] = 0;
      end else if (load) begin
        mq[i] = (int'(load_val) > mx) ? mx : int'(load_val);
        mtc[i] = 0; mph[i] = 0;
      end else if (en && mph[i] == ps - 1) begin
        mph[i] = 0;
        mtc[i] = 0;
        if (up_dn) begin
          if (mq[i] == mx) begin mtc[i] = 1; movf[i] = 1; mq[i] = sat_mode ? mx : 0; end
          else mq[i] = mq[i] + 1;
        end else begin
          if (mq[i] == 0) begin mtc[i] = 1; movf[i] = 1; mq[i] = sat_mode ? 0 : mx; end
          else mq[i] = mq[i] - 1;
        end
      end else begin
        if (en) mph[i] = mph[i] + 1;
        mtc[i] = 0;
      end
    end
  endtask
  task automatic check_all();
    check("qa", qa, mq[0]);
    check("tca", tca, mtc[0]);
    check("ovfa", ovfa, movf[0]);
    check("ma", ma, mq[0] == int'(cmp_val));
    check("qb", qb, mq[1]);
    check("tcb", tcb, mtc[1]);
    check("ovfb", ovfb, movf[1]);
    check("mb", mb, mq[1] == int'(cmp_val));
  endtask
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask
  task automatic set(input logic e, input logic u, input logic s, input logic c, input logic l, input logic [2:0] lv);
    en = e; up_dn = u; sat_mode = s; clr = c; load = l; load_val = lv;
  endtask
  initial begin
    model_reset();
    #3 check_all();
    #5 reset = 1'b0;
    tag = "up_wrap";
    set(1, 1, 0, 0, 0, 0);
    cyc(7);
    check("a_q7", qa, 7);
    cyc(1);
    check("a_wrap0", qa, 0);
    check("a_tc", tca, 1);
    cyc(2);
    check("a_ovf_sticky", ovfa, 1);
    tag = "down_sat";
    set(0, 0, 1, 1, 0, 0);
    cyc(1);
    set(0, 0, 1, 0, 1, 1);
    cyc(1);
    set(1, 0, 1, 0, 0, 0);
    cyc(16);
    check("b_sat0", qb, 0);
    set(0, 0, 1, 1, 0, 0);
    cyc(1);
    check("b_clr_ovf", ovfb, 0);
    tag = "priority";
    set(0, 1, 0, 1, 1, 4);
    cyc(1);
    check("a_clr_wins", qa, 0);
    set(0, 1, 0, 0, 1, 6);
    cyc(1);
    check("b_load_clamp", qb, 5);
    tag = "prescale";
    set(0, 1, 0, 1, 0, 0);
    cyc(1);
    set(1, 1, 0, 0, 0, 0);
    cyc(6);
    set(0, 1, 0, 0, 0, 0);
    cyc(2);
    set(1, 1, 0, 0, 0, 0);
    cyc(6);
    check("b_delayed", qb, 3);
    tag = "async_reset";
    set(0, 1, 0, 1, 0, 0);
    cyc(1);
    set(1, 1, 0, 0, 0, 0);
    cyc(5);
    check("a_q5", qa, 5);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
    cyc(1);
    check("a_resume1", qa, 1);
    tag = "compare";
    cmp_val = 3;
    set(0, 1, 0, 1, 0, 0);
    cyc(1);
    set(1, 1, 0, 0, 0, 0);
    cyc(3);
    check("a_match", ma, 1);
    set(1, 0, 0, 0, 0, 0);
    cyc(1);
    check("a_down2", qa, 2);
    tag = "random";
    for (int r = 0; r < 400; r++) begin
      set($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
          $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0, 3'($urandom));
      cmp_val = 3'($urandom);
      cyc(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
